inv_key_sched: RTL and testbench

//  Upstream key source for the decryption round datapath. Accepts one 128-bit cipher key,

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/inv_key_sched_g.sv | 20 ++
 rtl/inv_mix_columns.sv | 23 ++
 rtl/inv_key_sched.sv | 104 ++++++++++
 tb/tb_inv_key_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helpers
package aes_pkg;

   typedef logic [15:0][7:0] state_t;
   typedef logic [3:0][7:0]  word_t;

   localparam int NR = 10;

   // Index 0 and 11..15 are padding so any 4-bit counter value selects a defined entry.
   localparam logic [15:0][7:0] RCON = {
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h1b, 8'h80,
      8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
   };

   typedef enum logic [1:0] {IDLE, EXPAND, READY} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] acc;
      p   = 8'h00;
      acc = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ acc;
         acc = xtime(acc);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a);
      return {a[6:0], a[7]};
   endfunction

   // Forward S-box as multiplicative inverse (x^254, which maps 0 to 0) plus affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240, inv, r1, r2, r3, r4;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      r1   = rotl8(inv);
      r2   = rotl8(r1);
      r3   = rotl8(r2);
      r4   = rotl8(r3);
      return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
   endfunction

endpackage

// File: rtl/inv_key_sched_g.sv
// rtl/inv_key_sched_g.sv - key expansion g-function: RotWord, SubWord, Rcon XOR
module inv_key_sched_g
   import aes_pkg::*;
(
   input  word_t      w_in,
   input  logic [7:0] rcon,
   output word_t      g_out
);

   word_t rot;

   // Byte [3] is the leftmost word byte, so RotWord moves it to the bottom.
   assign rot = {w_in[2], w_in[1], w_in[0], w_in[3]};

   assign g_out[3] = sbox(rot[3]) ^ rcon;
   assign g_out[2] = sbox(rot[2]);
   assign g_out[1] = sbox(rot[1]);
   assign g_out[0] = sbox(rot[0]);

endmodule

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - combinational AES InvMixColumns over a full state
module inv_mix_columns
   import aes_pkg::*;
(
   input  state_t s_in,
   output state_t s_out
);

   always_comb begin
      s_out = '0;
      for (int c = 0; c < 4; c++) begin
         s_out[15-4*c] = gf_mul(8'h0e, s_in[15-4*c]) ^ gf_mul(8'h0b, s_in[14-4*c]) ^
                         gf_mul(8'h0d, s_in[13-4*c]) ^ gf_mul(8'h09, s_in[12-4*c]);
         s_out[14-4*c] = gf_mul(8'h09, s_in[15-4*c]) ^ gf_mul(8'h0e, s_in[14-4*c]) ^
                         gf_mul(8'h0b, s_in[13-4*c]) ^ gf_mul(8'h0d, s_in[12-4*c]);
         s_out[13-4*c] = gf_mul(8'h0d, s_in[15-4*c]) ^ gf_mul(8'h09, s_in[14-4*c]) ^
                         gf_mul(8'h0e, s_in[13-4*c]) ^ gf_mul(8'h0b, s_in[12-4*c]);
         s_out[12-4*c] = gf_mul(8'h0b, s_in[15-4*c]) ^ gf_mul(8'h0d, s_in[14-4*c]) ^
                         gf_mul(8'h09, s_in[13-4*c]) ^ gf_mul(8'h0e, s_in[12-4*c]);
      end
   end

endmodule

// File: rtl/inv_key_sched.sv
// rtl/inv_key_sched.sv - iterative AES-128 key expansion serving decryption round keys
module inv_key_sched
   import aes_pkg::*;
#(
   parameter bit EQUIV_INV = 1'b1,
   parameter int NR        = aes_pkg::NR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   input  logic [15:0][7:0] key_in,
   output logic             key_ready,
   output logic             keys_valid,
   input  logic [3:0]       rd_rc,
   output logic [15:0][7:0] rd_key,
   output logic             rd_err
);

   localparam logic [3:0] NR_L = 4'(NR);

   fsm_t       state, state_n;
   state_t     tbl [0:NR];
   logic [3:0] cnt;
   logic       accept;
   logic [3:0] prev_idx;
   state_t     prev;
   word_t      g_w, w4, w5, w6, w7;
   logic       rd_ok, rd_mix;
   logic [3:0] rd_idx;
   state_t     rd_raw, rd_imc;

   assign key_ready = (state != EXPAND);
   assign accept    = key_valid && key_ready;

   assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
   assign prev     = tbl[prev_idx];

   inv_key_sched_g u_g (
      .w_in  (prev[3:0]),
      .rcon  (RCON[cnt]),
      .g_out (g_w)
   );

   assign w4 = prev[15:12] ^ g_w;
   assign w5 = prev[11:8]  ^ w4;
   assign w6 = prev[7:4]   ^ w5;
   assign w7 = prev[3:0]   ^ w6;

   // Decryption round r uses encryption key NR-r; middle keys optionally pre-mixed.
   assign rd_ok  = (rd_rc <= NR_L);
   assign rd_idx = rd_ok ? (NR_L - rd_rc) : 4'd0;
   assign rd_raw = tbl[rd_idx];
   assign rd_mix = EQUIV_INV && (rd_rc != 4'd0) && (rd_rc < NR_L);

   inv_mix_columns u_imc (
      .s_in  (rd_raw),
      .s_out (rd_imc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, READY: if (accept) state_n = EXPAND;
         EXPAND:      if (cnt == NR_L) state_n = READY;
         default:     state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NR; i++) tbl[i] <= '0;
         cnt        <= 4'd0;
         keys_valid <= 1'b0;
      end else if (accept) begin
         tbl[0]     <= key_in;
         cnt        <= 4'd1;
         keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
         tbl[cnt] <= {w4, w5, w6, w7};
         if (cnt == NR_L) begin
            cnt        <= 4'd0;
            keys_valid <= 1'b1;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_key <= '0;
         rd_err <= 1'b0;
      end else begin
         rd_key <= !rd_ok ? '0 : (rd_mix ? rd_imc : rd_raw);
         rd_err <= !rd_ok;
      end
   end

endmodule

// File: tb/tb_inv_key_sched.sv
// tb/tb_inv_key_sched.sv - directed scoreboard bench for inv_key_sched
module tb_inv_key_sched;

   typedef struct {
      logic [3:0]   rc;
      logic [127:0] k_inv;
      logic [127:0] k_raw;
      logic         err;
   } exp_t;

   localparam logic [127:0] KEY1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KEY1_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] KEY1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY2    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] KEY2_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             key_valid;
   logic [15:0][7:0] key_in;
   logic [3:0]       rd_rc;
   logic             key_ready, keys_valid, rd_err;
   logic [15:0][7:0] rd_key;
   logic             key_ready_r, keys_valid_r, rd_err_r;
   logic [15:0][7:0] rd_key_r;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   inv_key_sched #(.EQUIV_INV(1'b1), .NR(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
      .key_ready(key_ready), .keys_valid(keys_valid), .rd_rc(rd_rc),
      .rd_key(rd_key), .rd_err(rd_err)
   );

   inv_key_sched #(.EQUIV_INV(1'b0), .NR(10)) u_raw (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
      .key_ready(key_ready_r), .keys_valid(keys_valid_r), .rd_rc(rd_rc),
      .rd_key(rd_key_r), .rd_err(rd_err_r)
   );

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_imc(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = ref_mul(a0, 8'h0e) ^ ref_mul(a1, 8'h0b) ^ ref_mul(a2, 8'h0d) ^ ref_mul(a3, 8'h09);
         o[119-32*c -: 8] = ref_mul(a0, 8'h09) ^ ref_mul(a1, 8'h0e) ^ ref_mul(a2, 8'h0b) ^ ref_mul(a3, 8'h0d);
         o[111-32*c -: 8] = ref_mul(a0, 8'h0d) ^ ref_mul(a1, 8'h09) ^ ref_mul(a2, 8'h0e) ^ ref_mul(a3, 8'h0b);
         o[103-32*c -: 8] = ref_mul(a0, 8'h0b) ^ ref_mul(a1, 8'h0d) ^ ref_mul(a2, 8'h09) ^ ref_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a read, push the expectation, pop and compare after the registering edge.
   task automatic rd(input logic [3:0] rc, input logic [127:0] k_raw, input logic err);
      exp_t e;
      rd_rc   = rc;
      e.rc    = rc;
      e.k_raw = k_raw;
      e.k_inv = (rc >= 4'd1 && rc <= 4'd9) ? ref_imc(k_raw) : k_raw;
      e.err   = err;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("rd_key_inv rc=%0d", e.rc), rd_key, e.k_inv);
      chk($sformatf("rd_key_raw rc=%0d", e.rc), rd_key_r, e.k_raw);
      chk($sformatf("rd_err rc=%0d", e.rc), {127'b0, rd_err}, {127'b0, e.err});
   endtask

   task automatic load_key(input logic [127:0] k, input int pulse_at, input logic [127:0] other);
      int n;
      key_valid = 1'b1;
      key_in    = k;
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("keys_valid on accept", {127'b0, keys_valid}, 128'd0);
      chk("key_ready on accept", {127'b0, key_ready}, 128'd0);
      n = 0;
      while (keys_valid !== 1'b1 && n < 20) begin
         if (n == pulse_at) begin
            key_valid = 1'b1;
            key_in    = other;
         end
         @(posedge clk); #1;
         key_valid = 1'b0;
         n++;
         if (keys_valid !== 1'b1) chk($sformatf("key_ready expand %0d", n), {127'b0, key_ready}, 128'd0);
      end
      chk("keys_valid latency", 128'(n), 128'd10);
      chk("key_ready ready", {127'b0, key_ready}, 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      rd_rc     = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset key_ready", {127'b0, key_ready}, 128'd1);
      chk("reset keys_valid", {127'b0, keys_valid}, 128'd0);
      chk("reset rd_key", rd_key, 128'd0);
      chk("reset rd_err", {127'b0, rd_err}, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      load_key(KEY1, -1, '0);
      rd(4'd0, KEY1_RA, 1'b0);
      rd(4'd10, KEY1, 1'b0);
      rd(4'd9, KEY1_R1, 1'b0);
      rd(4'd8, KEY1_R2, 1'b0);

      load_key(KEY2, -1, '0);
      rd(4'd0, KEY2_RA, 1'b0);
      rd(4'd9, KEY2_R1, 1'b0);
      rd(4'd10, KEY2, 1'b0);

      load_key(KEY1, 3, KEY2);
      rd(4'd0, KEY1_RA, 1'b0);
      rd(4'd9, KEY1_R1, 1'b0);

      for (int rc = 11; rc <= 15; rc++) rd(4'(rc), 128'd0, 1'b1);
      rd(4'd10, KEY1, 1'b0);

      key_valid = 1'b1;
      key_in    = KEY2;
      rd_rc     = 4'd10;
      @(posedge clk); #1;
      key_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid-expand rd_key", rd_key, KEY2);
      chk("mid-expand key_ready", {127'b0, key_ready}, 128'd0);
      rst_n = 1'b0;
      #1;
      chk("async reset rd_key", rd_key, 128'd0);
      chk("async reset rd_err", {127'b0, rd_err}, 128'd0);
      chk("async reset keys_valid", {127'b0, keys_valid}, 128'd0);
      chk("async reset key_ready", {127'b0, key_ready}, 128'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd(4'd10, 128'd0, 1'b0);
      rd(4'd0, 128'd0, 1'b0);
      chk("post reset keys_valid", {127'b0, keys_valid}, 128'd0);
      chk("post reset key_ready", {127'b0, key_ready}, 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
